// File: rtl/booth_pkg.sv
// Shared types and defaults for the radix-2 Booth multiplier sequencer.
package booth_pkg;

  localparam int WIDTH_IN_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINAL,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB
  } booth_op_t;

endpackage

// File: rtl/booth_sequencer_if.sv
// Start/done handshake plus partial-product register feedback of the Booth sequencer.
interface booth_sequencer_if #(
  parameter int WIDTH_IN = 16
) ();

  localparam int WIDTH_PP = 2*WIDTH_IN + 1;

  logic                  start_i;
  logic [WIDTH_IN-1:0]   a_i;
  logic                  ready_o;
  logic [WIDTH_PP-1:0]   pp_i;
  logic [WIDTH_PP-1:0]   pp_next_o;
  logic                  en_i_o;
  logic                  en_pp_o;
  logic                  en_fp_o;
  logic [2*WIDTH_IN-1:0] product_o;
  logic                  done_o;
  logic                  ack_i;

  modport master (
    output start_i, a_i, pp_i, ack_i,
    input  ready_o, pp_next_o, en_i_o, en_pp_o, en_fp_o, product_o, done_o
  );

  modport slave (
    input  start_i, a_i, pp_i, ack_i,
    output ready_o, pp_next_o, en_i_o, en_pp_o, en_fp_o, product_o, done_o
  );

endinterface

// File: rtl/booth_addsub.sv
// One radix-2 Booth step: encode the low pair, add/subtract the multiplicand into A,
// then arithmetic-shift the whole {A, Q, q-1} register right by one.
module booth_addsub
  import booth_pkg::*;
#(
  parameter int WIDTH_IN = WIDTH_IN_DEF,
  localparam int WIDTH_PP = 2*WIDTH_IN + 1
) (
  input  logic [WIDTH_PP-1:0] pp,
  input  logic [WIDTH_IN-1:0] mcand,
  output logic [WIDTH_PP-1:0] pp_next
);

  booth_op_t                op;
  logic signed [WIDTH_IN:0] a_ext;
  logic signed [WIDTH_IN:0] m_ext;
  logic signed [WIDTH_IN:0] sum;

  always_comb begin
    case (pp[1:0])
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NOP;
    endcase
  end

  // One guard bit keeps A - M correct when M is the most negative operand.
  assign a_ext = {pp[WIDTH_PP-1], pp[WIDTH_PP-1:WIDTH_IN+1]};
  assign m_ext = {mcand[WIDTH_IN-1], mcand};

  always_comb begin
    sum = a_ext;
    case (op)
      OP_ADD:  sum = a_ext + m_ext;
      OP_SUB:  sum = a_ext - m_ext;
      default: sum = a_ext;
    endcase
  end

  assign pp_next = {sum, pp[WIDTH_IN:1]};

endmodule

// File: rtl/booth_sequencer.sv
// Booth multiplier control: accepts a multiplicand, steps the external partial-product
// register through WIDTH_IN iterations, then captures and presents the product.
module booth_sequencer
  import booth_pkg::*;
#(
  parameter int WIDTH_IN = WIDTH_IN_DEF,
  localparam int WIDTH_PP = 2*WIDTH_IN + 1,
  localparam int CNT_W    = $clog2(WIDTH_IN) + 1
) (
  input logic              clk,
  input logic              reset,
  booth_sequencer_if.slave bus
);

  state_t                state;
  logic [WIDTH_IN-1:0]   mcand_q;
  logic [CNT_W-1:0]      cnt;
  logic [2*WIDTH_IN-1:0] product_q;
  logic                  done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mcand_q   <= '0;
      cnt       <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            mcand_q <= bus.a_i;
            cnt     <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH_IN - 1)) state <= FINAL;
        end
        FINAL: begin
          product_q <= bus.pp_i[WIDTH_PP-1:1];
          done_q    <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (bus.ack_i) begin
            done_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are state decodes so the register load lands in the same cycle as the accept.
  assign bus.ready_o   = (state == IDLE);
  assign bus.en_i_o    = (state == IDLE) && bus.start_i;
  assign bus.en_pp_o   = (state == CALC);
  assign bus.en_fp_o   = (state == FINAL);
  assign bus.product_o = product_q;
  assign bus.done_o    = done_q;

  booth_addsub #(
    .WIDTH_IN (WIDTH_IN)
  ) u_addsub (
    .pp      (bus.pp_i),
    .mcand   (mcand_q),
    .pp_next (bus.pp_next_o)
  );

endmodule
